// File: rtl/destruct_line_sequencer_pkg.sv
// destruct_line_sequencer_pkg: shared FSM encoding and defaults for the destruct_data sequencer
package destruct_line_sequencer_pkg;
  localparam int CW_DEF = 16;
  localparam int OUT_LAT_DEF = 1;
  localparam int FLAG_W = 3;
  typedef enum logic [1:0] {IDLE, ALIGN, RUN, GAP} state_t;
endpackage

// File: rtl/destruct_line_sequencer_flag_delay.sv
// dd_flag_delay: LAT-deep shift register keeping valid/eol/eof aligned with destruct_data odata
module dd_flag_delay
  import destruct_line_sequencer_pkg::*;
#(
  parameter int LAT = OUT_LAT_DEF,
  parameter int W = FLAG_W
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  if (LAT == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    logic [W-1:0] pipe [LAT];
    always_ff @(posedge clock or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= d;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    assign q = pipe[LAT-1];
  end
endmodule

// File: rtl/destruct_line_sequencer.sv
// destruct_line_sequencer: frames the destruct_data read stream into lines/frames and drives ialign/force_rd/ord_en
module destruct_line_sequencer
  import destruct_line_sequencer_pkg::*;
#(
  parameter int CW = CW_DEF,
  parameter int OUT_LAT = OUT_LAT_DEF,
  parameter bit LINE_ALIGN = 1'b1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [CW-1:0] hactive,
  input  logic [CW-1:0] vactive,
  input  logic [CW-1:0] hblank,
  input  logic          fifo_empty,
  input  logic          pix_ready,
  output logic          dd_ialign,
  output logic          dd_force_rd,
  output logic          dd_ord_en,
  output logic          pix_valid,
  output logic          pix_eol,
  output logic          pix_eof,
  output logic          busy,
  output logic          err_restart
);
  state_t state, state_n, line_start;
  logic [CW-1:0] hcnt, hcnt_n, vcnt, vcnt_n, gcnt, gcnt_n, h_last, v_last, hblank_r;
  logic can_rd, h_end, v_end, fin, restart;
  logic [FLAG_W-1:0] flags;
  assign busy = state != IDLE;
  assign h_end = hcnt == h_last;
  assign v_end = vcnt == v_last;
  assign can_rd = state == RUN && pix_ready && !fifo_empty;
  assign fin = can_rd && h_end && v_end;
  // a restart landing on the frame's final read is a clean back-to-back start, not an error
  assign restart = frame_start && busy && !fin;
  assign err_restart = restart;
  assign dd_ord_en = can_rd && !restart;
  assign dd_ialign = state == ALIGN;
  assign dd_force_rd = state == ALIGN;
  assign line_start = LINE_ALIGN ? ALIGN : RUN;
  always_comb begin
    state_n = state;
    hcnt_n = hcnt;
    vcnt_n = vcnt;
    gcnt_n = gcnt;
    if (state == ALIGN) begin
      state_n = RUN;
      hcnt_n = '0;
    end
    if (dd_ord_en) begin
      hcnt_n = h_end ? '0 : hcnt + CW'(1);
      if (h_end) begin
        vcnt_n = v_end ? '0 : vcnt + CW'(1);
        state_n = v_end ? IDLE : (hblank_r == '0 ? line_start : GAP);
      end
    end
    if (state == GAP) begin
      gcnt_n = gcnt == hblank_r - CW'(1) ? '0 : gcnt + CW'(1);
      state_n = gcnt == hblank_r - CW'(1) ? line_start : GAP;
    end
    if (frame_start) begin
      state_n = ALIGN;
      hcnt_n = '0;
      vcnt_n = '0;
      gcnt_n = '0;
    end
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      hcnt <= '0;
      vcnt <= '0;
      gcnt <= '0;
      h_last <= '0;
      v_last <= '0;
      hblank_r <= '0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      vcnt <= vcnt_n;
      gcnt <= gcnt_n;
      if (frame_start) begin
        h_last <= hactive == '0 ? '0 : hactive - CW'(1);
        v_last <= vactive == '0 ? '0 : vactive - CW'(1);
        hblank_r <= hblank;
      end
    end
  dd_flag_delay #(.LAT(OUT_LAT), .W(FLAG_W)) u_flag_delay (
    .clock(clock),
    .rst_n(rst_n),
    .d({dd_ord_en, dd_ord_en && h_end, dd_ord_en && h_end && v_end}),
    .q(flags)
  );
  assign {pix_valid, pix_eol, pix_eof} = flags;
endmodule

// File: tb/tb_destruct_line_sequencer.sv
// tb_destruct_line_sequencer: scoreboard bench for destruct_line_sequencer
module tb_destruct_line_sequencer;
  import destruct_line_sequencer_pkg::*;
  localparam int CW = CW_DEF;
  logic clock = 1'b0, rst_n = 1'b0, frame_start = 1'b0, fs0 = 1'b0, fifo_empty = 1'b0, pix_ready = 1'b1;
  logic [CW-1:0] hactive = '0, vactive = '0, hblank = '0;
  logic dd_ialign, dd_force_rd, dd_ord_en, pix_valid, pix_eol, pix_eof, busy, err_restart;
  logic d0_ialign, d0_force_rd, d0_ord_en, d0_valid, d0_eol, d0_eof, d0_busy, d0_err;
  int n_tests = 0, n_fail = 0, cyc = 0, base = 0;
  int n_ord = 0, n_pop = 0, n_err = 0;
  int n0_ord = 0, n0_ia = 0, n0_eol = 0, n0_eof = 0, first0 = -1, last0 = 0;
  int ia_rel[$];
  logic [1:0] exp_q[$];
  logic prev_ord = 1'b0;
  destruct_line_sequencer u_dut (
    .clock(clock), .rst_n(rst_n), .frame_start(frame_start),
    .hactive(hactive), .vactive(vactive), .hblank(hblank),
    .fifo_empty(fifo_empty), .pix_ready(pix_ready),
    .dd_ialign(dd_ialign), .dd_force_rd(dd_force_rd), .dd_ord_en(dd_ord_en),
    .pix_valid(pix_valid), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .busy(busy), .err_restart(err_restart)
  );
  destruct_line_sequencer #(.LINE_ALIGN(1'b0)) u_dut0 (
    .clock(clock), .rst_n(rst_n), .frame_start(fs0),
    .hactive(hactive), .vactive(vactive), .hblank(hblank),
    .fifo_empty(fifo_empty), .pix_ready(pix_ready),
    .dd_ialign(d0_ialign), .dd_force_rd(d0_force_rd), .dd_ord_en(d0_ord_en),
    .pix_valid(d0_valid), .pix_eol(d0_eol), .pix_eof(d0_eof),
    .busy(d0_busy), .err_restart(d0_err)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic clear_stats();
    n_ord = 0;
    n_pop = 0;
    n_err = 0;
    ia_rel.delete();
  endtask
  task automatic push_frame(input int h, input int v);
    int hh, vv;
    hh = h == 0 ? 1 : h;
    vv = v == 0 ? 1 : v;
    for (int y = 0; y < vv; y++)
      for (int x = 0; x < hh; x++)
        exp_q.push_back({x == hh - 1, x == hh - 1 && y == vv - 1});
  endtask
  task automatic start_frame(input int h, input int v, input int b);
    push_frame(h, v);
    hactive = CW'(h);
    vactive = CW'(v);
    hblank = CW'(b);
    frame_start = 1'b1;
    base = cyc;
    tick(1);
    frame_start = 1'b0;
  endtask
  task automatic wait_ord(input int n);
    int t;
    t = 0;
    while (n_ord < n && t < 200) begin
      tick(1);
      t++;
    end
    check("wait_ord", n_ord, n);
  endtask
  task automatic wait_idle(input bit tog);
    int t;
    t = 0;
    while (busy && t < 500) begin
      tick(1);
      if (tog) pix_ready = ~pix_ready;
      t++;
    end
    check("idle_timeout", busy, 0);
    pix_ready = 1'b1;
    tick(3);
    check("sb_drain", exp_q.size(), 0);
  endtask
  // sample just before each rising edge, when this cycle's ord_en is what the DUT will act on
  always begin
    logic [1:0] e;
    @(negedge clock);
    #4;
    if (!rst_n) prev_ord = 1'b0;
    else begin
      if (pix_valid) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("flags", {pix_eol, pix_eof}, e);
          n_pop++;
        end
      end else check("flags_idle", {pix_eol, pix_eof}, 2'b00);
      check("valid_lat", pix_valid, prev_ord);
      if (dd_ord_en) check("ord_gate", {pix_ready, fifo_empty, dd_ialign}, 3'b100);
      check("force_rd", dd_force_rd, dd_ialign);
      if (dd_ialign) ia_rel.push_back(cyc - base);
      n_ord += int'(dd_ord_en);
      n_err += int'(err_restart);
      prev_ord = dd_ord_en;
    end
  end
  always begin
    @(negedge clock);
    #4;
    if (rst_n) begin
      if (d0_ord_en) begin
        if (first0 < 0) first0 = cyc;
        last0 = cyc;
        n0_ord++;
      end
      n0_ia += int'(d0_ialign);
      n0_eol += int'(d0_valid && d0_eol);
      n0_eof += int'(d0_valid && d0_eof);
    end
  end
  initial begin
    int k, keep, rb, t;
    #3;
    check("rst_busy", busy, 0);
    check("rst_outs", {dd_ord_en, dd_ialign, dd_force_rd, pix_valid, pix_eol, pix_eof, err_restart}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    clear_stats();
    start_frame(4, 2, 3);
    wait_idle(1'b0);
    check("t1_ord", n_ord, 8);
    check("t1_pop", n_pop, 8);
    check("t1_ia_n", ia_rel.size(), 2);
    if (ia_rel.size() == 2) begin
      check("t1_ia0", ia_rel[0], 1);
      check("t1_ia1", ia_rel[1], 9);
    end
    check("t1_err", n_err, 0);
    clear_stats();
    start_frame(4, 2, 3);
    wait_idle(1'b1);
    check("t2_ord", n_ord, 8);
    check("t2_pop", n_pop, 8);
    clear_stats();
    start_frame(4, 2, 3);
    wait_ord(2);
    fifo_empty = 1'b1;
    k = n_ord;
    tick(5);
    check("t3_stall", n_ord, k);
    fifo_empty = 1'b0;
    wait_idle(1'b0);
    check("t3_ord", n_ord, 8);
    clear_stats();
    start_frame(4, 2, 3);
    wait_ord(2);
    keep = n_ord - n_pop;
    while (exp_q.size() > keep) void'(exp_q.pop_back());
    push_frame(4, 2);
    frame_start = 1'b1;
    rb = cyc;
    tick(1);
    frame_start = 1'b0;
    check("t4_err_pulse", n_err, 1);
    wait_idle(1'b0);
    check("t4_err_once", n_err, 1);
    check("t4_ord", n_ord, 10);
    check("t4_ia_n", ia_rel.size(), 3);
    if (ia_rel.size() == 3) check("t4_ia_restart", ia_rel[1], rb + 1 - base);
    clear_stats();
    start_frame(2, 1, 0);
    tick(2);
    push_frame(3, 1);
    hactive = CW'(3);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    wait_idle(1'b0);
    check("t4b_err", n_err, 0);
    check("t4b_ord", n_ord, 5);
    hactive = CW'(3);
    vactive = CW'(3);
    hblank = '0;
    fs0 = 1'b1;
    tick(1);
    fs0 = 1'b0;
    t = 0;
    while (d0_busy && t < 200) begin
      tick(1);
      t++;
    end
    check("t5_idle", d0_busy, 0);
    tick(3);
    check("t5_ia", n0_ia, 1);
    check("t5_ord", n0_ord, 9);
    check("t5_span", last0 - first0 + 1, 9);
    check("t5_eol", n0_eol, 3);
    check("t5_eof", n0_eof, 1);
    clear_stats();
    start_frame(4, 2, 3);
    wait_ord(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_outs", {dd_ord_en, dd_ialign, dd_force_rd, pix_valid, pix_eol, pix_eof, err_restart}, 0);
    tick(2);
    exp_q.delete();
    rst_n = 1'b1;
    k = n_ord;
    tick(6);
    check("t6_idle", busy, 0);
    check("t6_no_ord", n_ord, k);
    clear_stats();
    start_frame(0, 0, 5);
    wait_idle(1'b0);
    check("t7_ord", n_ord, 1);
    check("t7_pop", n_pop, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
